// File: rtl/alu_selftest.sv
// alu_selftest: BIST engine that sweeps all {s,a,b} vectors through an external 4-bit ALU and checks y against a golden model.
module alu_selftest #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_s,
    input  logic [3:0]  alu_y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [11:0] err_count,
    output logic [10:0] first_fail_vec,
    output logic [3:0]  first_fail_y
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state;
    logic [10:0] idx;
    logic [3:0]  cnt;
    logic [3:0]  gold;
    logic        mis, tick, last;
    assign {alu_s, alu_a, alu_b} = idx;
    assign mis  = alu_y != gold;
    assign tick = cnt == 4'(SETTLE - 1);
    assign last = &idx;
    always_comb begin
        gold = 4'd0;
        case (alu_s)
            3'd0: gold = alu_a + alu_b;
            3'd1: gold = alu_a - alu_b;
            3'd2: gold = alu_a & alu_b;
            3'd3: gold = alu_a | alu_b;
            3'd4: gold = alu_a ^ alu_b;
            3'd5: gold = ~alu_a;
            3'd6: gold = alu_a << 1;
            default: gold = alu_a >> 1;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_y   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state          <= RUN;
                    busy           <= 1'b1;
                    idx            <= '0;
                    cnt            <= '0;
                    pass           <= 1'b0;
                    err_count      <= '0;
                    first_fail_vec <= '0;
                    first_fail_y   <= '0;
                end
                RUN: if (tick) begin
                    cnt <= '0;
                    if (mis) begin
                        err_count <= err_count + 12'd1;
                        if (err_count == '0) begin
                            first_fail_vec <= idx;
                            first_fail_y   <= alu_y;
                        end
                    end
                    // the final vector's own mismatch must also clear pass
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mis;
                    end else begin
                        idx <= idx + 11'd1;
                    end
                end else begin
                    cnt <= cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_selftest.sv
// tb_alu_selftest: drives two alu_selftest instances (SETTLE=1 and 3) against a modelled ALU with selectable faults.
module tb_alu_selftest;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_v[2];
    logic [3:0]  a_v[2], b_v[2], y_v[2];
    logic [2:0]  s_v[2];
    logic        busy_v[2], done_v[2], pass_v[2];
    logic [11:0] err_v[2];
    logic [10:0] ffv_v[2], vec_v[2];
    logic [3:0]  ffy_v[2];
    logic [3:0]  d1[2], d2[2];
    logic [3:0]  mask[2048];
    int          mode_v[2];
    int          checks = 0, errors = 0;

    typedef struct {int mode; int err; int ffv; int ffy; int pass;} vec_t;
    vec_t tbl[3];

    always #5 clk = ~clk;

    alu_selftest #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .alu_a(a_v[0]), .alu_b(b_v[0]), .alu_s(s_v[0]), .alu_y(y_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
        .first_fail_vec(ffv_v[0]), .first_fail_y(ffy_v[0]));
    alu_selftest #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .alu_a(a_v[1]), .alu_b(b_v[1]), .alu_s(s_v[1]), .alu_y(y_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
        .first_fail_vec(ffv_v[1]), .first_fail_y(ffy_v[1]));

    function automatic logic [3:0] gold(int s, int a, int b);
        case (s)
            0: return 4'((a + b) % 16);
            1: return 4'((a - b + 16) % 16);
            2: return 4'(a & b);
            3: return 4'(a | b);
            4: return 4'(a ^ b);
            5: return 4'(15 - a);
            6: return 4'((a * 2) % 16);
            default: return 4'(a / 2);
        endcase
    endfunction

    function automatic logic [3:0] gv(int v);
        return gold(v / 256, (v / 16) % 16, v % 16);
    endfunction

    // modes: 0 golden, 1 single injected fault, 2 y[3] stuck at 0, 3 two-cycle delay, 4 random mask
    function automatic logic [3:0] resp(int m, logic [10:0] v, logic [3:0] dly, logic [3:0] mk);
        logic [3:0] g;
        g = gv(int'(v));
        return m == 1 ? (v == 11'h029 ? 4'hf : v == 11'h229 ? 4'h0 : g) :
               m == 2 ? (g & 4'h7) : m == 3 ? dly : m == 4 ? (g ^ mk) : g;
    endfunction

    for (genvar w = 0; w < 2; w++) begin : g_alu
        assign vec_v[w] = {s_v[w], a_v[w], b_v[w]};
        assign y_v[w]   = resp(mode_v[w], vec_v[w], d2[w], mask[vec_v[w]]);
        always_ff @(posedge clk) begin
            d1[w] <= gv(int'(vec_v[w]));
            d2[w] <= d1[w];
        end
    end

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", n, act, exp);
        end
    endtask

    task automatic run(input int w, input bit poke, input int exp_done, output int done_at, output int busy_n);
        @(negedge clk);
        start_v[w] = 1'b1;
        @(posedge clk);
        #1;
        start_v[w] = 1'b0;
        chk("clear_err", int'(err_v[w]), 0);
        chk("clear_ffv", int'(ffv_v[w]), 0);
        chk("clear_ffy", int'(ffy_v[w]), 0);
        chk("clear_pass", int'(pass_v[w]), 0);
        busy_n  = int'(busy_v[w]);
        done_at = -1;
        for (int c = 1; c <= exp_done + 50 && done_at < 0; c++) begin
            if (poke && (vec_v[w] == 11'd10 || vec_v[w] == 11'd2047)) start_v[w] = 1'b1;
            @(posedge clk);
            #1;
            start_v[w] = 1'b0;
            busy_n += int'(busy_v[w]);
            if (done_v[w]) done_at = c;
        end
        if (poke) start_v[w] = 1'b1;
        @(posedge clk);
        #1;
        start_v[w] = 1'b0;
        chk("done_single", int'(done_v[w]), 0);
        chk("idle_busy", int'(busy_v[w]), 0);
        @(posedge clk);
        #1;
        chk("no_restart", int'(busy_v[w]), 0);
    endtask

    task automatic chk_res(input int w, input int e, input int fv, input int fy, input int p);
        chk("err_count", int'(err_v[w]), e);
        chk("first_fail_vec", int'(ffv_v[w]), fv);
        chk("first_fail_y", int'(ffy_v[w]), fy);
        chk("pass", int'(pass_v[w]), p);
    endtask

    initial begin
        int da, bn, n3, ee, ef, ey;
        start_v = '{1'b0, 1'b0};
        mode_v  = '{0, 0};
        foreach (mask[i]) mask[i] = 4'd0;
        n3 = 0;
        for (int v = 0; v < 2048; v++) if (gv(v) >= 8) n3++;
        tbl[0] = '{0, 0, 0, 0, 1};
        tbl[1] = '{1, 1, 11'h029, 15, 0};
        tbl[2] = '{2, n3, 8, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_v[0]), 0);
        chk("rst_done", int'(done_v[0]), 0);
        chk("rst_vec", int'(vec_v[0]), 0);
        chk_res(0, 0, 0, 0, 0);
        chk("rst_busy3", int'(busy_v[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            mode_v[0] = tbl[i].mode;
            run(0, 1'b0, 2048, da, bn);
            chk("done_at", da, 2048);
            chk("busy_cycles", bn, 2048);
            chk_res(0, tbl[i].err, tbl[i].ffv, tbl[i].ffy, tbl[i].pass);
        end
        for (int r = 0; r < 3; r++) begin
            ee = 0; ef = 0; ey = 0;
            foreach (mask[v]) begin
                mask[v] = ($urandom_range(0, 99) < 3) ? 4'($urandom_range(1, 15)) : 4'd0;
                if (mask[v] != 0) begin
                    if (ee == 0) begin
                        ef = v;
                        ey = int'(gv(v) ^ mask[v]);
                    end
                    ee++;
                end
            end
            mode_v[0] = 4;
            run(0, 1'b0, 2048, da, bn);
            chk("rand_done_at", da, 2048);
            chk_res(0, ee, ef, ey, ee == 0 ? 1 : 0);
        end
        mode_v[0] = 3;
        run(0, 1'b0, 2048, da, bn);
        chk("delay_s1_pass", int'(pass_v[0]), 0);
        mode_v[1] = 3;
        run(1, 1'b0, 6144, da, bn);
        chk("s3_done_at", da, 6144);
        chk("s3_busy_cycles", bn, 6144);
        chk_res(1, 0, 0, 0, 1);
        mode_v[0] = 1;
        run(0, 1'b0, 2048, da, bn);
        chk("pre_poke_err", int'(err_v[0]), 1);
        mode_v[0] = 0;
        run(0, 1'b1, 2048, da, bn);
        chk("poke_done_at", da, 2048);
        chk("poke_busy_cycles", bn, 2048);
        chk_res(0, 0, 0, 0, 1);
        mode_v[0] = 2;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (int c = 0; c < 600 && vec_v[0] != 11'd500; c++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_500", int'(vec_v[0]), 500);
        chk("mid_err_nonzero", int'(err_v[0] != 0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy_v[0]), 0);
        chk("arst_vec", int'(vec_v[0]), 0);
        chk_res(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bn = 0;
        repeat (2100) begin
            @(posedge clk);
            #1;
            bn += int'(done_v[0]) + int'(busy_v[0]);
        end
        chk("no_done_after_rst", bn, 0);
        mode_v[0] = 0;
        run(0, 1'b0, 2048, da, bn);
        chk("post_rst_done_at", da, 2048);
        chk("post_rst_pass", int'(pass_v[0]), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_selftest.md
# alu_selftest

Synthesizable built-in self-test engine for the 4-bit, 3-bit-select combinational `alu`. It acts as the stimulus-and-response end of the ALU interface: it drives `a`, `b` and `s` into an external `alu` instance and samples that instance's `y`. It sweeps all 2048 operand/opcode combinations, compares each result against an internal golden model, and reports pass/fail, an error count and the first failing vector. It sits beside the ALU in the datapath and is triggered by a one-cycle `start`.

## Interface
- `SETTLE`, default 1: number of cycles each vector is held on the ALU inputs before `y` is sampled; legal range 1–15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `alu_a`  out  4  operand A to the ALU; registered.
- `alu_b`  out  4  operand B to the ALU; registered.
- `alu_s`  out  3  opcode to the ALU; registered.
- `alu_y`  in  4  ALU result; combinational return from the ALU.
- `busy`  out  1  high from the first vector through the last sample.
- `done`  out  1  one-cycle pulse when the run completes.
- `pass`  out  1  1 when `err_count` is 0; valid from `done` until the next accepted `start`.
- `err_count`  out  12  number of mismatching vectors in the run (maximum 2048).
- `first_fail_vec`  out  11  `{s,a,b}` of the first mismatch; 0 if there is none.
- `first_fail_y`  out  4  `alu_y` captured at the first mismatch; 0 if there is none.

## Operation
- **Golden model.** All results are truncated to 4 bits.
  - 000: a+b
  - 001: a−b (mod 16)
  - 010: a&b
  - 011: a|b
  - 100: a^b
  - 101: ~a
  - 110: a<<1
  - 111: a>>1 (logical)
- **Vector order.** An 11-bit index `{s,a,b}` counts from 0 to 2047, so b is the innermost loop and s the outermost. `alu_s/alu_a/alu_b` = index fields.
- **FSM states.** IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1. On that edge: index←0, `err_count`←0, first-fail registers←0, `pass`←0, settle counter←0.
  - RUN: the settle counter counts 0..SETTLE−1. On the edge where counter==SETTLE−1:
    - compare `alu_y` with the golden result for the current index;
    - on mismatch, increment `err_count`, and if it was 0, load `first_fail_vec`/`first_fail_y`;
    - then the index increments and the counter clears.
    - If the index was 2047, go to DONE instead of incrementing.
  - DONE: lasts one cycle with `done`=1, then returns to IDLE. `pass`←(`err_count`==0) on entry to DONE, including a mismatch found on the final vector.
- `start` in RUN or DONE is ignored; it is not queued.
- Results (`err_count`, `pass`, first-fail registers) hold in IDLE until the next accepted `start`.

## Timing
- **Reset values:** `alu_a`=0, `alu_b`=0, `alu_s`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_y`=0; state = IDLE.
- **Reset mid-run:** immediate return to reset values; no partial result is retained. The run restarts only on a new `start` after `rst_n` deasserts.
- **Run start:** `start` sampled high at edge T0. Vector 0 appears on the ALU ports after T0 and `busy`=1 from T0.
- **Sampling:** vector k is driven from edge T0+k·SETTLE and sampled at edge T0+(k+1)·SETTLE. The ALU therefore has SETTLE full cycles, minus clock-to-out, to settle.
- **Completion:** the last sample is at T0+2048·SETTLE. `busy` drops and `done`=1 during the following cycle, and IDLE resumes one edge later. For SETTLE=1, `done` is high in the cycle after edge T0+2048.
- **Back-to-back runs:** `start` is accepted one cycle after `done`, i.e. in IDLE.

## Test plan
- **Golden ALU, SETTLE=1.** `rst_n` low, then high; pulse `start`. Required: `busy` for 2048 cycles, a single `done` pulse exactly at T0+2048, `pass`=1, `err_count`=0, `first_fail_vec`=0.
- **Single injected fault.** The bench ALU returns 4'b0000 only for a=4'b0010, b=4'b1001, s=3'b010 (golden is 4'b0000, so no error there) and 4'b1111 for the same a/b with s=3'b000 (golden 4'b1011). Required: `err_count`=1, `first_fail_vec`=11'b000_0010_1001, `first_fail_y`=4'b1111, `pass`=0.
- **Stuck-at on y[3].** Force `alu_y[3]`=0. Required: `err_count` equals the golden-model count of vectors with result bit 3 set, `first_fail_vec`=11'b000_0000_1000, `first_fail_y`=4'b0000.
- **SETTLE=3.** Bench ALU delays `y` by 2 cycles. Required: `pass`=1 and `done` at T0+6144. With SETTLE=1 under the same delay, required: `pass`=0.
- **Reset mid-run.** Assert `rst_n`=0 at vector 500. Required: all outputs return to reset values asynchronously and no `done` occurs. A subsequent `start` completes a full run with `pass`=1.
- **Start while busy.** Pulse `start` at vectors 10 and 2047 and in the DONE cycle. Required: no restart and `done` timing unchanged. A second `start` after IDLE clears the previous results on its accepting edge.
